bip_execute_unit: RTL



---
 rtl/bip_pkg.sv | 24 ++
 rtl/bip_data_memory.sv | 27 ++
 rtl/bip_execute_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared BIP definitions: field widths, opcode values and execute-stage states.
package bip_pkg;

  localparam int DATA_W      = 16;
  localparam int OPCODE_W    = 5;
  localparam int OPERAND_W   = 11;
  localparam int DMEM_ADDR_W = 10;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    ST_EXEC     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/bip_data_memory.sv
// Single-port data RAM: synchronous write, registered read (one-cycle latency).
// A write at edge N is visible to a read issued in cycle N+1.
module bip_data_memory #(
  parameter int DATA_W      = 16,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [DMEM_ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic [DATA_W-1:0]      o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<DMEM_ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port and registered read of the addressed word; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bip_execute_unit.sv
// BIP execute stage: decodes the live instruction, owns the accumulator and
// data memory, and stalls the PC while a memory-read instruction completes.
module bip_execute_unit #(
  parameter int DATA_W      = 16,
  parameter int DMEM_ADDR_W = 10,
  parameter int OPCODE_W    = 5,
  parameter int OPERAND_W   = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OPCODE_W+OPERAND_W-1:0] instruction,
  output logic                          pc_enable,
  output logic [DATA_W-1:0]             acc_out,
  output logic                          halted,
  output logic [15:0]                   clk_count
);

  import bip_pkg::*;

  localparam int EXT_W = DATA_W - OPERAND_W;

  logic [OPCODE_W-1:0]    w_opcode;
  logic [OPERAND_W-1:0]   w_operand;
  logic [DMEM_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]      w_imm;
  logic [DATA_W-1:0]      w_rdata;
  logic [DATA_W-1:0]      w_acc_nxt;
  logic                   w_mem_we;
  logic                   w_pc_enable;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [OPCODE_W-1:0]    r_op;
  logic [DATA_W-1:0]      r_acc;
  logic                   r_halted;
  logic [15:0]            r_clk_count;

  assign w_opcode  = instruction[OPCODE_W+OPERAND_W-1:OPERAND_W];
  assign w_operand = instruction[OPERAND_W-1:0];
  assign w_addr    = w_operand[DMEM_ADDR_W-1:0];
  assign w_imm     = {{EXT_W{w_operand[OPERAND_W-1]}}, w_operand};
  assign w_mem_we  = (!reset) && (r_state == ST_EXEC) && (w_opcode == OP_STO);

  bip_data_memory #(
    .DATA_W      (DATA_W),
    .DMEM_ADDR_W (DMEM_ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_addr),
    .i_wdata (r_acc),
    .o_rdata (w_rdata)
  );

  // State register; reset aborts any pending read and returns to EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EXEC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: memory reads take a wait cycle, HLT parks the stage until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EXEC: begin
        case (w_opcode)
          OP_HLT:                     w_state_nxt = ST_HALT;
          OP_LD, OP_ADD, OP_SUB:      w_state_nxt = ST_MEM_WAIT;
          default:                    w_state_nxt = ST_EXEC;
        endcase
      end
      ST_MEM_WAIT: w_state_nxt = ST_EXEC;
      ST_HALT:     w_state_nxt = ST_HALT;
      default:     w_state_nxt = ST_EXEC;
    endcase
  end

  // PC advance permission: held low for the issue cycle of reads, for HLT and in reset.
  always_comb begin
    w_pc_enable = 1'b0;
    if (reset) begin
      w_pc_enable = 1'b0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          case (w_opcode)
            OP_HLT, OP_LD, OP_ADD, OP_SUB: w_pc_enable = 1'b0;
            default:                       w_pc_enable = 1'b1;
          endcase
        end
        ST_MEM_WAIT: w_pc_enable = 1'b1;
        ST_HALT:     w_pc_enable = 1'b0;
        default:     w_pc_enable = 1'b0;
      endcase
    end
  end

  // Accumulator update: immediates in EXEC, memory operands when read data returns.
  always_comb begin
    w_acc_nxt = r_acc;
    case (r_state)
      ST_EXEC: begin
        case (w_opcode)
          OP_LDI:  w_acc_nxt = w_imm;
          OP_ADDI: w_acc_nxt = r_acc + w_imm;
          OP_SUBI: w_acc_nxt = r_acc - w_imm;
          default: w_acc_nxt = r_acc;
        endcase
      end
      ST_MEM_WAIT: begin
        case (r_op)
          OP_LD:   w_acc_nxt = w_rdata;
          OP_ADD:  w_acc_nxt = r_acc + w_rdata;
          OP_SUB:  w_acc_nxt = r_acc - w_rdata;
          default: w_acc_nxt = r_acc;
        endcase
      end
      default: w_acc_nxt = r_acc;
    endcase
  end

  // Accumulator and captured opcode; the opcode register feeds the MEM_WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= {DATA_W{1'b0}};
      r_op  <= {OPCODE_W{1'b0}};
    end else begin
      r_acc <= w_acc_nxt;
      if (r_state == ST_EXEC) begin
        r_op <= w_opcode;
      end else begin
        r_op <= r_op;
      end
    end
  end

  // Halt flag and saturating count of non-halted cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted    <= 1'b0;
      r_clk_count <= 16'h0000;
    end else begin
      r_halted <= (w_state_nxt == ST_HALT);
      if ((r_state != ST_HALT) && (r_clk_count != 16'hFFFF)) begin
        r_clk_count <= r_clk_count + 16'h0001;
      end else begin
        r_clk_count <= r_clk_count;
      end
    end
  end

  assign pc_enable = w_pc_enable;
  assign acc_out   = r_acc;
  assign halted    = r_halted;
  assign clk_count = r_clk_count;

endmodule
